// File: rtl/pipeline_datapath_fwd_pkg.sv
// Shared types and helpers for the forwarding datapath: opcodes, LFSR taps,
// instruction field extraction and the checksum rotate.
package pipeline_datapath_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_LDI = 3'd7
    } op_e;

    // Feedback taps 31, 21, 1, 0 of the 32-bit self-stimulus LFSR.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] ifield(input logic [31:0] instr,
                                           input int unsigned lsb,
                                           input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (instr >> lsb) & mask;
    endfunction

    function automatic logic [63:0] rotl1(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/pipeline_datapath_fwd_if.sv
// Instruction-in and result-out valid/ready streams of the forwarding datapath.
interface pipeline_datapath_fwd_if #(
    parameter int XLEN    = 32,
    parameter int RIDX    = 3,
    parameter int INSTR_W = 28
);
    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               res_valid;
    logic               res_ready;
    logic [XLEN-1:0]    res_data;
    logic [RIDX-1:0]    res_rd;

    modport master (
        output in_valid, in_instr, res_ready,
        input  in_ready, res_valid, res_data, res_rd
    );

    modport slave (
        input  in_valid, in_instr, res_ready,
        output in_ready, res_valid, res_data, res_rd
    );
endinterface

// File: rtl/pipeline_datapath_fwd_alu.sv
// Combinational execute stage: wrapping integer ops, logical shifts, immediate load.
module pipe_alu
    import pipeline_datapath_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16
) (
    input  op_e              op_i,
    input  logic [XLEN-1:0]  src1_i,
    input  logic [XLEN-1:0]  src2_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic [XLEN-1:0]  result_o
);
    localparam int SHW = $clog2(XLEN);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = src1_i + src2_i;
            OP_SUB:  result_o = src1_i - src2_i;
            OP_AND:  result_o = src1_i & src2_i;
            OP_OR:   result_o = src1_i | src2_i;
            OP_XOR:  result_o = src1_i ^ src2_i;
            OP_SHL:  result_o = src1_i << src2_i[SHW-1:0];
            OP_SHR:  result_o = src1_i >> src2_i[SHW-1:0];
            OP_LDI:  result_o = XLEN'(imm_i);
            default: result_o = '0;
        endcase
    end
endmodule

// File: rtl/pipeline_datapath_fwd.sv
// Three-stage decode/execute/writeback core with full EX/WB bypass, LFSR or
// external instruction source, and a backpressured result stream.
module pipeline_datapath_fwd
    import pipeline_datapath_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          NREGS     = 8,
    parameter int          IMM_W     = 16,
    parameter bit          ZERO_R0   = 1'b1,
    parameter logic [31:0] LFSR_SEED = 32'hCAFEBABE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_ext,
    pipeline_datapath_fwd_if.slave  bus,
    output logic [XLEN-1:0]         checksum,
    output logic [31:0]             retired
);
    localparam int RIDX    = $clog2(NREGS);
    localparam int INSTR_W = 3 + 3 * RIDX + IMM_W;

    if (INSTR_W > 32) begin : g_instr_w_check
        $fatal(1, "pipeline_datapath_fwd: instruction word wider than 32 bits");
    end

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [31:0]      lfsr_q, lfsr_d;
    logic             s2_valid_q, s3_valid_q;
    op_e              s2_op_q;
    logic [RIDX-1:0]  s2_rd_q, s3_rd_q;
    logic [XLEN-1:0]  s2_a_q, s2_b_q, s3_res_q, alu_res;
    logic [IMM_W-1:0] s2_imm_q;
    logic [XLEN-1:0]  checksum_q, checksum_d;
    logic [31:0]      retired_q;

    logic             stall, issue;
    logic [31:0]      instr_w;
    op_e              dec_op;
    logic [RIDX-1:0]  dec_rd;
    logic [RIDX-1:0]  dec_rs [2];
    logic [IMM_W-1:0] dec_imm;

    assign stall = s3_valid_q && !bus.res_ready;
    assign issue = rst_n && !stall && (cfg_ext ? bus.in_valid : 1'b1);

    assign bus.in_ready  = rst_n && cfg_ext && !stall;
    assign bus.res_valid = s3_valid_q;
    assign bus.res_data  = s3_res_q;
    assign bus.res_rd    = s3_rd_q;
    assign checksum      = checksum_q;
    assign retired       = retired_q;

    assign instr_w   = cfg_ext ? 32'(bus.in_instr) : 32'(lfsr_q[INSTR_W-1:0]);
    assign dec_op    = op_e'(3'(ifield(instr_w, 0, 3)));
    assign dec_rd    = RIDX'(ifield(instr_w, 3, RIDX));
    assign dec_rs[0] = RIDX'(ifield(instr_w, 3 + RIDX, RIDX));
    assign dec_rs[1] = RIDX'(ifield(instr_w, 3 + 2 * RIDX, RIDX));
    assign dec_imm   = IMM_W'(ifield(instr_w, 3 + 3 * RIDX, IMM_W));

    // Youngest producer wins: the instruction in execute shadows the one in writeback.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [XLEN-1:0] val;
        always_comb begin
            val = regs_q[dec_rs[gi]];
            if (ZERO_R0 && dec_rs[gi] == '0) begin
                val = '0;
            end else if (s2_valid_q && s2_rd_q == dec_rs[gi]) begin
                val = alu_res;
            end else if (s3_valid_q && s3_rd_q == dec_rs[gi]) begin
                val = s3_res_q;
            end
        end
    end

    pipe_alu #(.XLEN(XLEN), .IMM_W(IMM_W)) u_alu (
        .op_i     (s2_op_q),
        .src1_i   (s2_a_q),
        .src2_i   (s2_b_q),
        .imm_i    (s2_imm_q),
        .result_o (alu_res)
    );

    assign lfsr_d     = (issue && !cfg_ext) ? {lfsr_q[30:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
    assign checksum_d = XLEN'(rotl1(64'(checksum_q), XLEN)) ^ s3_res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q     <= LFSR_SEED;
            s2_valid_q <= 1'b0;
            s2_op_q    <= OP_ADD;
            s2_rd_q    <= '0;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
            s2_imm_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_rd_q    <= '0;
            s3_res_q   <= '0;
            checksum_q <= '0;
            retired_q  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (!stall) begin
            lfsr_q     <= lfsr_d;
            s2_valid_q <= issue;
            if (issue) begin
                s2_op_q  <= dec_op;
                s2_rd_q  <= dec_rd;
                s2_a_q   <= g_fwd[0].val;
                s2_b_q   <= g_fwd[1].val;
                s2_imm_q <= dec_imm;
            end
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_rd_q  <= s2_rd_q;
                s3_res_q <= alu_res;
            end
            if (s3_valid_q) begin
                if (!(ZERO_R0 && s3_rd_q == '0)) begin
                    regs_q[s3_rd_q] <= s3_res_q;
                end
                checksum_q <= checksum_d;
                retired_q  <= retired_q + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_datapath_fwd.sv
// Scenario bench for pipeline_datapath_fwd: directed program checks plus a
// randomized mixed-mode run against a sequential instruction-set model.
module tb_pipeline_datapath_fwd;
    localparam logic [31:0] SEED = 32'hCAFEBABE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_ext;
    logic [31:0] checksum;
    logic [31:0] retired;

    pipeline_datapath_fwd_if #(.XLEN(32), .RIDX(3), .INSTR_W(28)) bus ();

    pipeline_datapath_fwd dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_ext  (cfg_ext),
        .bus      (bus),
        .checksum (checksum),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Sequential-semantics model: every issued instruction sees all older results.
    logic [31:0] model_regs [8];
    logic [31:0] model_ck;
    int          model_cnt;
    logic [31:0] tb_lfsr;
    logic [31:0] exp_data [$];
    logic [2:0]  exp_rd   [$];
    logic [31:0] obs_data [$];
    logic [2:0]  obs_rd   [$];
    bit          acc_last;

    function automatic logic [27:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [15:0] imm);
        return {imm, rs2, rs1, rd, op};
    endfunction

    function automatic logic [31:0] rot32(input logic [31:0] v);
        return {v[30:0], v[31]};
    endfunction

    task automatic model_issue(input logic [27:0] ins);
        logic [31:0] a, b, r;
        a = (ins[8:6] == 3'd0) ? 32'd0 : model_regs[ins[8:6]];
        b = (ins[11:9] == 3'd0) ? 32'd0 : model_regs[ins[11:9]];
        case (ins[2:0])
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[4:0];
            3'd6: r = a >> b[4:0];
            default: r = {16'd0, ins[27:12]};
        endcase
        if (ins[5:3] != 3'd0) model_regs[ins[5:3]] = r;
        exp_data.push_back(r);
        exp_rd.push_back(ins[5:3]);
        model_ck  = rot32(model_ck) ^ r;
        model_cnt = model_cnt + 1;
    endtask

    // One clock: observe handshakes at the falling edge, end just after the rising edge.
    task automatic step();
        bit stalled;
        @(negedge clk);
        acc_last = 1'b0;
        if (rst_n) begin
            if (bus.res_valid && bus.res_ready) begin
                obs_data.push_back(bus.res_data);
                obs_rd.push_back(bus.res_rd);
            end
            stalled = bus.res_valid && !bus.res_ready;
            if (cfg_ext) begin
                acc_last = bus.in_valid && bus.in_ready;
                if (acc_last) model_issue(bus.in_instr);
            end else begin
                acc_last = !stalled;
                if (acc_last) begin
                    model_issue(tb_lfsr[27:0]);
                    tb_lfsr = {tb_lfsr[30:0], tb_lfsr[31] ^ tb_lfsr[21] ^ tb_lfsr[1] ^ tb_lfsr[0]};
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit ext);
        rst_n = 1'b0;
        cfg_ext = ext;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        model_ck = '0;
        model_cnt = 0;
        tb_lfsr = SEED;
        exp_data.delete(); exp_rd.delete();
        obs_data.delete(); obs_rd.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [27:0] prog [$];

    task automatic run_prog(input int gap);
        int idx = 0;
        int g = 0;
        for (int cyc = 0; cyc < 200 && idx < prog.size(); cyc++) begin
            if (g > 0) begin
                bus.in_valid = 1'b0;
                step();
                g--;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_instr = prog[idx];
                step();
                if (acc_last) begin
                    idx++;
                    g = gap;
                end
            end
        end
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 50 && obs_data.size() < exp_data.size(); cyc++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_ext = 1'b1;
        bus.in_valid = 1'b1;
        bus.res_ready = 1'b1;
        #3;
        n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_tests++; if (checksum !== 32'd0) begin n_fail++; $display("FAIL reset_checksum got %h want 0", checksum); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired); end
        n_tests++; if (bus.res_data !== 32'd0) begin n_fail++; $display("FAIL reset_res_data got %h want 0", bus.res_data); end
        $display("[TB] reset: res_valid=%b in_ready=%b checksum=%h retired=%0d", bus.res_valid, bus.in_ready, checksum, retired);
    endtask

    task automatic test_forwarding();
        logic [31:0] want [3];
        logic [2:0]  want_rd [3];
        want = '{32'd5, 32'd3, 32'd8};
        want_rd = '{3'd1, 3'd2, 3'd3};
        do_reset(1'b1);
        prog = '{enc(3'd7, 3'd1, 3'd0, 3'd0, 16'd5), enc(3'd7, 3'd2, 3'd0, 3'd0, 16'd3),
                 enc(3'd0, 3'd3, 3'd1, 3'd2, 16'd0)};
        run_prog(0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= obs_data.size() || obs_data[i] !== want[i] || obs_rd[i] !== want_rd[i]) begin
                n_fail++;
                $display("FAIL fwd_result[%0d] got %h/r%0d want %h/r%0d", i, obs_data[i], obs_rd[i], want[i], want_rd[i]);
            end
            $display("[TB] fwd: result %0d = %0d rd %0d", i, obs_data[i], obs_rd[i]);
        end
        n_tests++; if (checksum !== 32'h1A) begin n_fail++; $display("FAIL fwd_checksum got %h want 1a", checksum); end
        n_tests++; if (retired !== 32'd3) begin n_fail++; $display("FAIL fwd_retired got %0d want 3", retired); end
    endtask

    task automatic test_wrap_shift();
        do_reset(1'b1);
        prog = '{enc(3'd7, 3'd1, 3'd0, 3'd0, 16'd0), enc(3'd7, 3'd2, 3'd0, 3'd0, 16'd1),
                 enc(3'd1, 3'd5, 3'd1, 3'd2, 16'd0), enc(3'd5, 3'd6, 3'd2, 3'd2, 16'd0)};
        run_prog(0);
        n_tests++;
        if (obs_data.size() != 4 || obs_data[2] !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_sub got %h want ffffffff", obs_data[2]);
        end
        n_tests++;
        if (obs_data.size() != 4 || obs_data[3] !== 32'd2) begin
            n_fail++; $display("FAIL shift_shl got %h want 2", obs_data[3]);
        end
        $display("[TB] wrap/shift: sub=%h shl=%h", obs_data[2], obs_data[3]);
    endtask

    task automatic test_zero_reg();
        do_reset(1'b1);
        prog = '{enc(3'd7, 3'd0, 3'd0, 3'd0, 16'd7), enc(3'd0, 3'd4, 3'd0, 3'd0, 16'd0)};
        run_prog(0);
        n_tests++;
        if (obs_data.size() != 2 || obs_data[0] !== 32'd7 || obs_rd[0] !== 3'd0) begin
            n_fail++; $display("FAIL zero_ldi got %h/r%0d want 7/r0", obs_data[0], obs_rd[0]);
        end
        n_tests++;
        if (obs_data.size() != 2 || obs_data[1] !== 32'd0) begin
            n_fail++; $display("FAIL zero_read got %h want 0", obs_data[1]);
        end
        n_tests++; if (retired !== 32'd2) begin n_fail++; $display("FAIL zero_retired got %0d want 2", retired); end
        $display("[TB] zero reg: ldi r0 -> %h, add r0+r0 -> %h", obs_data[0], obs_data[1]);
    endtask

    task automatic test_backpressure();
        logic [27:0] p3 [3];
        logic [31:0] want [3];
        logic [31:0] snap_d, snap_r;
        int idx = 0;
        bit held = 1'b0;
        do_reset(1'b1);
        p3 = '{enc(3'd7, 3'd1, 3'd0, 3'd0, 16'd5), enc(3'd7, 3'd2, 3'd0, 3'd0, 16'd3),
               enc(3'd0, 3'd3, 3'd1, 3'd2, 16'd0)};
        want = '{32'd5, 32'd3, 32'd8};
        for (int cyc = 0; cyc < 60 && obs_data.size() < 3; cyc++) begin
            if (!held && bus.res_valid) begin
                held = 1'b1;
                bus.res_ready = 1'b0;
                snap_d = bus.res_data;
                snap_r = retired;
                for (int k = 0; k < 3; k++) begin
                    step();
                    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, bus.in_ready); end
                    n_tests++; if (bus.res_data !== snap_d) begin n_fail++; $display("FAIL bp_res_data[%0d] got %h want %h", k, bus.res_data, snap_d); end
                    n_tests++; if (retired !== snap_r) begin n_fail++; $display("FAIL bp_retired[%0d] got %0d want %0d", k, retired, snap_r); end
                    $display("[TB] bp stall %0d: in_ready=%b res_data=%h retired=%0d", k, bus.in_ready, bus.res_data, retired);
                end
                bus.res_ready = 1'b1;
            end
            bus.in_valid = (idx < 3);
            bus.in_instr = (idx < 3) ? p3[idx] : 28'd0;
            step();
            if (acc_last) idx++;
        end
        bus.in_valid = 1'b0;
        n_tests++; if (!held) begin n_fail++; $display("FAIL bp_res_valid got 0 want 1"); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= obs_data.size() || obs_data[i] !== want[i]) begin
                n_fail++; $display("FAIL bp_result[%0d] got %h want %h", i, obs_data[i], want[i]);
            end
        end
        n_tests++; if (retired !== 32'd3) begin n_fail++; $display("FAIL bp_retired_end got %0d want 3", retired); end
    endtask

    task automatic test_bubbles_reset();
        do_reset(1'b1);
        prog = '{enc(3'd7, 3'd1, 3'd0, 3'd0, 16'd9), enc(3'd0, 3'd2, 3'd1, 3'd1, 16'd0)};
        run_prog(2);
        n_tests++;
        if (obs_data.size() != 2 || obs_data[1] !== 32'd18) begin
            n_fail++; $display("FAIL bubble_add got %h want 12", obs_data[1]);
        end
        $display("[TB] bubbles: add r1+r1 -> %0d", obs_data[1]);
        bus.in_valid = 1'b1;
        bus.in_instr = enc(3'd7, 3'd3, 3'd0, 3'd0, 16'd1);
        step();
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b0;
        step();
        step();
        n_tests++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got %b want 1", bus.res_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_res_valid got %b want 0", bus.res_valid); end
        n_tests++; if (checksum !== 32'd0) begin n_fail++; $display("FAIL midrst_checksum got %h want 0", checksum); end
        n_tests++; if (retired !== 32'd0) begin n_fail++; $display("FAIL midrst_retired got %0d want 0", retired); end
        $display("[TB] mid reset: res_valid=%b checksum=%h retired=%0d", bus.res_valid, checksum, retired);
    endtask

    task automatic test_lfsr();
        logic [31:0] ck;
        int bad;
        do_reset(1'b0);
        for (int i = 0; i < 100; i++) step();
        n_tests++; if (retired !== 32'd98) begin n_fail++; $display("FAIL lfsr_retired got %0d want 98", retired); end
        n_tests++;
        if (obs_data.size() != 98) begin n_fail++; $display("FAIL lfsr_count got %0d want 98", obs_data.size()); end
        ck = '0;
        bad = 0;
        for (int i = 0; i < 98 && i < obs_data.size(); i++) begin
            ck = rot32(ck) ^ exp_data[i];
            n_tests++;
            if (obs_data[i] !== exp_data[i] || obs_rd[i] !== exp_rd[i]) begin
                n_fail++; bad++;
                $display("FAIL lfsr_result[%0d] got %h/r%0d want %h/r%0d", i, obs_data[i], obs_rd[i], exp_data[i], exp_rd[i]);
            end
        end
        n_tests++; if (checksum !== ck) begin n_fail++; $display("FAIL lfsr_checksum got %h want %h", checksum, ck); end
        $display("[TB] lfsr: retired=%0d checksum=%h model=%h mismatches=%0d", retired, checksum, ck, bad);
    endtask

    task automatic test_random_mixed();
        int bad = 0;
        do_reset(1'b1);
        for (int i = 0; i < 400; i++) begin
            cfg_ext = ($urandom_range(0, 9) != 0);
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.in_instr = 28'($urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cfg_ext = 1'b1;
        bus.in_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && obs_data.size() < exp_data.size(); cyc++) step();
        n_tests++;
        if (obs_data.size() != exp_data.size()) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", obs_data.size(), exp_data.size());
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            n_tests++;
            if (obs_data[i] !== exp_data[i] || obs_rd[i] !== exp_rd[i]) begin
                n_fail++; bad++;
                $display("FAIL rand_result[%0d] got %h/r%0d want %h/r%0d", i, obs_data[i], obs_rd[i], exp_data[i], exp_rd[i]);
            end
        end
        n_tests++; if (checksum !== model_ck) begin n_fail++; $display("FAIL rand_checksum got %h want %h", checksum, model_ck); end
        n_tests++; if (retired !== 32'(model_cnt)) begin n_fail++; $display("FAIL rand_retired got %0d want %0d", retired, model_cnt); end
        $display("[TB] random: %0d retired, checksum=%h, mismatches=%0d", retired, checksum, bad);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_ext = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.res_ready = 1'b1;
        test_reset();
        test_forwarding();
        test_wrap_shift();
        test_zero_reg();
        test_backpressure();
        test_bubbles_reset();
        test_lfsr();
        test_random_mixed();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipeline_datapath_fwd.md
Name: pipeline_datapath_fwd

Overview:
Parametrised 3-stage (decode/execute/writeback) integer datapath, the successor to the fixed 8x32 self-stimulus pipeline. Adds generic width and register count, full EX/WB-to-decode forwarding, per-stage valid bits, and a selectable instruction source: internal LFSR or an external valid/ready stream. Retired results leave on a valid/ready stream with backpressure that stalls the whole pipe. It serves as a simulator stress block and as a reusable execution core in the test suite.

Parameters:
XLEN, 32, datapath and register width (>=8, power of two).
NREGS, 8, register-file depth (power of two, >=2); RIDX = $clog2(NREGS).
IMM_W, 16, immediate field width (<= XLEN).
ZERO_R0, 1, 1: r0 reads as 0 and writes to it are discarded.
LFSR_SEED, 32'hCAFEBABE, LFSR reset value (must be nonzero).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cfg_ext  in  1  1: external instruction stream; 0: internal LFSR.
in_valid  in  1  external instruction valid.
in_instr  in  INSTR_W  instruction word; INSTR_W = 3+3*RIDX+IMM_W (28 by default).
in_ready  out  1  instruction accepted when in_valid && in_ready.
res_valid  out  1  result valid (s3 occupied).
res_ready  in  1  consumer ready.
res_data  out  XLEN  result of the instruction in s3.
res_rd  out  RIDX  destination register of that result.
checksum  out  XLEN  running rotate-xor of retired results.
retired  out  32  count of retired instructions.

Behaviour:
- Reset is asynchronous, active-low, and fully effective immediately. Cleared state: all stage valid bits, regfile, checksum, retired, res_data, res_rd. LFSR = LFSR_SEED. After reset, in_ready = 0 and res_valid = 0 until rst_n deasserts. Assertion mid-operation drops all in-flight instructions.
- Instruction fields, LSB first: op[2:0], rd, rs1, rs2 (RIDX bits each), then imm (IMM_W bits). In LFSR mode the instruction is lfsr[INSTR_W-1:0]. INSTR_W > 32 is illegal (elaboration assertion).
- LFSR: 32-bit, next = {l[30:0], l[31]^l[21]^l[1]^l[0]}. It advances only on cycles where stage 1 issues in LFSR mode.
- stall = s3_valid && !res_ready. While stalled: s2, s3, LFSR and regfile hold; no writeback.
- Issue: in LFSR mode, issues every non-stall cycle. In external mode, in_ready = !stall and issue occurs on in_valid && in_ready. A non-issue, non-stall cycle inserts a bubble (s2_valid = 0).
- Latency: an instruction issued at edge E0 is in s2 after E0 and in s3 after E0+1. res_valid rises then, and it retires at the first later edge with res_ready = 1.
- Operand read, with forwarding priority: (1) s2 alu_result if s2_valid && s2_rd == rs; (2) s3 result if s3_valid && s3_rd == rs; (3) regfile. With ZERO_R0, rs == 0 yields 0 and bypasses are ignored.
- ALU (results XLEN, wrapping):
  - 0 add, 1 sub, 2 and, 3 or, 4 xor.
  - 5 shl and 6 shr (logical) by src2[$clog2(XLEN)-1:0].
  - 7 ldi: imm zero-extended.
- Retire (s3_valid && res_ready):
  - regfile[rd] <= result, unless rd == 0 && ZERO_R0.
  - checksum <= rotl1(checksum) ^ result.
  - retired += 1, wrapping at 2^32.
  - The result is still presented and counted when rd = 0.
- res_data and res_rd remain stable while stalled.
- cfg_ext may change at any cycle and takes effect for the next issue; in-flight instructions complete unaffected.

Decomposition:
- Package pipeline_datapath_pkg holds:
  - opcode enum op_e (OP_ADD … OP_LDI);
  - the LFSR tap constants;
  - a parametrisable instruction-field extraction function;
  - the rotl1 checksum function.
- One sub-module, pipe_alu: purely combinational, parametrised by XLEN, taking op, src1, src2 and imm.
- Regfile and forwarding stay in the top module.

Test Plan:
- Forwarding: ext mode, res_ready = 1, back-to-back LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> res_data sequence 5, 3, 8. ADD takes r2 from s2 and r1 from s3. Checksum ends 0x1A, retired = 3.
- Wrap and shift: LDI r1,0; LDI r2,1; SUB r5,r1,r2; SHL r6,r2,r2 -> 0xFFFFFFFF, then 2.
- Zero register: LDI r0,7; ADD r4,r0,r0 -> res_data 7 (res_rd 0), then 0; regfile[0] stays 0.
- Backpressure: during the 3-instruction stream, hold res_ready = 0 for 3 cycles once res_valid = 1 -> in_ready = 0, res_data stable, retired frozen. After release the sequence completes unchanged (5, 3, 8).
- Bubbles and reset: drop in_valid for 2 cycles between LDI r1,9 and ADD r2,r1,r1 -> 18. Pull rst_n low mid-stream -> res_valid, checksum and retired go to 0 without a clock edge.
- LFSR mode: cfg_ext = 0, res_ready = 1, 100 edges after reset release -> retired = 98. The first s2 op equals 0xCAFEBABE[2:0] = 6. The checksum matches the reference model.
